// File: rtl/dlfloat_result_serializer.sv
// -----------------------------------------------------------------------------
// dlfloat_result_serializer
//
// Buffers 16-bit DLfloat16 MAC results in a small FIFO and emits each one as a
// three-byte frame on an 8-bit valid/ready bus:
//   byte 0 : header {4'hA, 1'b0, nan, zero, neg}
//   byte 1 : result[15:8]
//   byte 2 : result[7:0]
// Frames are fully flow controlled; a byte is never retracted while waiting.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_in_valid   i_in_data holds a result to push
//   i_in_data    DLfloat16 result {sign, exp[5:0], mant[8:0]}
//   o_in_ready   FIFO can accept a push this cycle (level != DEPTH)
//   o_out_valid  o_out_byte holds a frame byte
//   o_out_byte   current frame byte
//   i_out_ready  consumer accepts o_out_byte this cycle
//   o_level      number of FIFO entries stored
//   o_drop_cnt   saturating count of results offered while the FIFO was full
// -----------------------------------------------------------------------------
module dlfloat_result_serializer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_valid,
  input  logic [15:0]   i_in_data,
  output logic          o_in_ready,
  output logic          o_out_valid,
  output logic [7:0]    o_out_byte,
  input  logic          i_out_ready,
  output logic [CW-1:0] o_level,
  output logic [7:0]    o_drop_cnt
);

  localparam int            AW       = CW - 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_MSB  = 2'd2,
    ST_LSB  = 2'd3
  } state_t;

  // {nan, zero, neg}; a NaN pattern has its sign bit set but is not negative
  function automatic logic [2:0] calc_flags(input logic [15:0] d);
    logic f_nan;
    logic f_zero;
    f_nan  = (d == 16'hFFFF);
    f_zero = (d == 16'h0000);
    return {f_nan, f_zero, d[15] & ~f_nan};
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [2:0] f);
    return {4'hA, 1'b0, f};
  endfunction

  logic [15:0]   r_mem  [DEPTH];
  logic [2:0]    r_flag [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_level;
  logic [7:0]    r_drop_cnt;
  state_t        r_state;
  logic          r_out_valid;
  logic [7:0]    r_out_byte;

  logic          w_in_ready;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic [2:0]    w_in_flags;
  logic [AW-1:0] w_rptr_inc;
  logic [CW-1:0] w_level_nxt;
  logic [2:0]    w_nxt_flags;

  assign w_in_ready = (r_level != LP_DEPTH);
  assign w_push     = i_in_valid && w_in_ready;
  assign w_drop     = i_in_valid && !w_in_ready;
  // The head is popped only when the LSB byte is accepted, so it stays stable
  // for the whole frame.
  assign w_pop      = (r_state == ST_LSB) && r_out_valid && i_out_ready;
  assign w_in_flags = calc_flags(i_in_data);
  assign w_rptr_inc = r_rptr + AW'(1);

  // Occupancy after this edge's push/pop
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + CW'(1);
      2'b01:   w_level_nxt = r_level - CW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Header flags of the entry that becomes head after a pop; when the FIFO
  // holds only the departing entry, the new head is the one being pushed now
  // and is not in the array yet, so take it straight from the input.
  always_comb begin
    w_nxt_flags = r_flag[w_rptr_inc];
    if ((r_level == CW'(1)) && w_push) begin
      w_nxt_flags = w_in_flags;
    end else begin
      w_nxt_flags = r_flag[w_rptr_inc];
    end
  end

  // FIFO storage write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i]  <= 16'h0000;
        r_flag[i] <= 3'b000;
      end
    end else if (w_push) begin
      r_mem[r_wptr]  <= i_in_data;
      r_flag[r_wptr] <= w_in_flags;
    end
  end

  // Pointers, occupancy and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_drop_cnt <= 8'h00;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= w_rptr_inc;
      end
      r_level <= w_level_nxt;
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // Output framing FSM with registered byte/valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_level != CW'(0)) begin
            r_state     <= ST_HDR;
            r_out_valid <= 1'b1;
            r_out_byte  <= hdr_byte(r_flag[r_rptr]);
          end else begin
            r_out_valid <= 1'b0;
            r_out_byte  <= 8'h00;
          end
        end
        ST_HDR: begin
          if (i_out_ready) begin
            r_state    <= ST_MSB;
            r_out_byte <= r_mem[r_rptr][15:8];
          end
        end
        ST_MSB: begin
          if (i_out_ready) begin
            r_state    <= ST_LSB;
            r_out_byte <= r_mem[r_rptr][7:0];
          end
        end
        ST_LSB: begin
          if (i_out_ready) begin
            if (w_level_nxt != CW'(0)) begin
              r_state     <= ST_HDR;
              r_out_valid <= 1'b1;
              r_out_byte  <= hdr_byte(w_nxt_flags);
            end else begin
              r_state     <= ST_IDLE;
              r_out_valid <= 1'b0;
              r_out_byte  <= 8'h00;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_out_byte  <= 8'h00;
        end
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_byte  = r_out_byte;
  assign o_level     = r_level;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_dlfloat_result_serializer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for dlfloat_result_serializer: table-driven frame
// vectors plus hand-written sequences for backpressure, reset and overflow.
// -----------------------------------------------------------------------------
module tb_dlfloat_result_serializer;

  logic        clk;
  logic        rst_n;
  logic        i_in_valid;
  logic [15:0] i_in_data;
  logic        o_in_ready;
  logic        o_out_valid;
  logic [7:0]  o_out_byte;
  logic        i_out_ready;
  logic [2:0]  o_level;
  logic [7:0]  o_drop_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  hdr;
    logic [7:0]  msb;
    logic [7:0]  lsb;
  } vec_t;

  vec_t        tab [7];
  logic [15:0] push_data [16];
  logic [7:0]  exp_bytes [16];

  dlfloat_result_serializer #(.DEPTH(4), .CW(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .i_in_data   (i_in_data),
    .o_in_ready  (o_in_ready),
    .o_out_valid (o_out_valid),
    .o_out_byte  (o_out_byte),
    .i_out_ready (i_out_ready),
    .o_level     (o_level),
    .o_drop_cnt  (o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Copy table rows [start, start+n) into the push list and expected byte list
  task automatic load(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      push_data[i]       = tab[start + i].data;
      exp_bytes[3*i]     = tab[start + i].hdr;
      exp_bytes[3*i + 1] = tab[start + i].msb;
      exp_bytes[3*i + 2] = tab[start + i].lsb;
    end
  endtask

  // Push n_push entries back-to-back with out_ready=1 and collect n_bytes
  // bytes, requiring no gap once output has started.
  task automatic run(input int n_push, input int n_bytes, input bit chk_lat);
    int pi;
    int got;
    int first_c;
    pi = 0;
    got = 0;
    first_c = -1;
    i_out_ready = 1'b1;
    if (n_push > 0) begin
      i_in_valid = 1'b1;
      i_in_data  = push_data[0];
      pi = 1;
    end
    for (int c = 0; c < 64 && got < n_bytes; c++) begin
      if (o_out_valid) begin
        if (first_c < 0) first_c = c;
        check("frame_byte", 16'(o_out_byte), 16'(exp_bytes[got]));
        got++;
      end else if (got > 0) begin
        check("no_gap", 16'(o_out_valid), 16'd1);
      end
      @(posedge clk); #1;
      if (pi < n_push) begin
        i_in_data = push_data[pi];
        pi++;
      end else begin
        i_in_valid = 1'b0;
      end
    end
    check("byte_count", 16'(got), 16'(n_bytes));
    if (chk_lat) check("latency", 16'(first_c), 16'd2);
    check("idle_valid", 16'(o_out_valid), 16'd0);
    check("idle_level", 16'(o_level), 16'd0);
  endtask

  initial begin
    logic [5:0] pat;
    int idx;

    tab[0] = '{16'h3E00, 8'hA0, 8'h3E, 8'h00};
    tab[1] = '{16'hFFFF, 8'hA4, 8'hFF, 8'hFF};
    tab[2] = '{16'h0000, 8'hA2, 8'h00, 8'h00};
    tab[3] = '{16'hBE00, 8'hA1, 8'hBE, 8'h00};
    tab[4] = '{16'h8001, 8'hA1, 8'h80, 8'h01};
    tab[5] = '{16'h7FFF, 8'hA0, 8'h7F, 8'hFF};
    tab[6] = '{16'hFFFE, 8'hA1, 8'hFF, 8'hFE};

    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_in_data   = 16'h0000;
    i_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 16'(o_out_valid), 16'd0);
    check("rst_byte", 16'(o_out_byte), 16'h00);
    check("rst_level", 16'(o_level), 16'd0);
    check("rst_drop", 16'(o_drop_cnt), 16'd0);
    check("rst_in_ready", 16'(o_in_ready), 16'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame with latency check
    load(0, 1);
    run(1, 3, 1'b1);

    // Back-to-back frames, flag variants
    load(1, 3);
    run(3, 9, 1'b1);
    load(4, 3);
    run(3, 9, 1'b1);

    // Fill while stalled, overflow by two, then drain in order
    i_out_ready = 1'b0;
    push_data[0] = 16'h9111; push_data[1] = 16'h2222; push_data[2] = 16'h0000;
    push_data[3] = 16'h4444; push_data[4] = 16'h5555; push_data[5] = 16'h6666;
    for (int i = 0; i < 6; i++) begin
      i_in_valid = 1'b1;
      i_in_data  = push_data[i];
      @(posedge clk); #1;
    end
    i_in_valid = 1'b0;
    check("full_level", 16'(o_level), 16'd4);
    check("full_in_ready", 16'(o_in_ready), 16'd0);
    check("full_drop", 16'(o_drop_cnt), 16'd2);
    check("stall_valid", 16'(o_out_valid), 16'd1);
    check("stall_hdr", 16'(o_out_byte), 16'hA1);
    exp_bytes[0] = 8'hA1; exp_bytes[1]  = 8'h91; exp_bytes[2]  = 8'h11;
    exp_bytes[3] = 8'hA0; exp_bytes[4]  = 8'h22; exp_bytes[5]  = 8'h22;
    exp_bytes[6] = 8'hA2; exp_bytes[7]  = 8'h00; exp_bytes[8]  = 8'h00;
    exp_bytes[9] = 8'hA0; exp_bytes[10] = 8'h44; exp_bytes[11] = 8'h44;
    run(0, 12, 1'b0);
    check("drop_kept", 16'(o_drop_cnt), 16'd2);

    // Backpressure pattern 1,0,0,1,0,1 within one frame
    exp_bytes[0] = 8'hA1; exp_bytes[1] = 8'hC3; exp_bytes[2] = 8'hA5;
    i_in_valid = 1'b1;
    i_in_data  = 16'hC3A5;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    for (int w = 0; w < 8 && !o_out_valid; w++) begin
      @(posedge clk); #1;
    end
    check("bp_start", 16'(o_out_valid), 16'd1);
    pat = 6'b101001;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      i_out_ready = pat[i];
      check("bp_valid", 16'(o_out_valid), 16'd1);
      check("bp_byte", 16'(o_out_byte), 16'(exp_bytes[idx]));
      @(posedge clk); #1;
      if (pat[i]) idx++;
    end
    check("bp_done", 16'(o_out_valid), 16'd0);
    check("bp_level", 16'(o_level), 16'd0);

    // Reset while in MSB with three entries queued
    i_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_in_valid = 1'b1;
      i_in_data  = 16'h1230 + 16'(i);
      @(posedge clk); #1;
    end
    i_in_valid = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    check("pre_rst_msb", 16'(o_out_byte), 16'h12);
    check("pre_rst_level", 16'(o_level), 16'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 16'(o_out_valid), 16'd0);
    check("mid_rst_level", 16'(o_level), 16'd0);
    check("mid_rst_drop", 16'(o_drop_cnt), 16'd0);
    check("mid_rst_byte", 16'(o_out_byte), 16'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", 16'(o_out_valid), 16'd0);
    end
    load(5, 1);
    run(1, 3, 1'b1);

    // Drop counter saturation
    i_out_ready = 1'b0;
    i_in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      i_in_data = 16'(i);
      @(posedge clk); #1;
      if (i == 257) check("drop_254", 16'(o_drop_cnt), 16'd254);
    end
    i_in_valid = 1'b0;
    check("drop_sat", 16'(o_drop_cnt), 16'hFF);
    check("sat_level", 16'(o_level), 16'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dlfloat_result_serializer.md
Name: dlfloat_result_serializer

Overview:
- Downstream of the DLfloat16 MAC. Accepts 16-bit MAC results through a valid/ready handshake and buffers them in a small FIFO.
- Each result is emitted as a 3-byte frame on an 8-bit valid/ready output: header byte, result MSB, result LSB.
- Replaces free-running MSB/LSB toggling with flow-controlled, self-describing output suitable for the 8-bit pad bus.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, 3, occupancy counter width; equals log2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a MAC result to push.
- in_data  input  16  DLfloat16 result {sign, exp[5:0], mant[8:0]}.
- in_ready  output  1  FIFO can accept a push this cycle.
- out_valid  output  1  out_byte holds a frame byte.
- out_byte  output  8  current frame byte.
- out_ready  input  1  consumer accepts out_byte this cycle.
- level  output  CW  number of FIFO entries currently stored.
- drop_cnt  output  8  saturating count of results offered while the FIFO was full.

Behaviour:
- Reset: asynchronous, active-low; clk and rst_n as stated.
  - While rst_n=0: FIFO pointers=0, level=0, drop_cnt=0, FSM=IDLE, out_valid=0, out_byte=8'h00.
  - A reset asserted mid-frame discards the frame and all FIFO contents immediately. No partial frame resumes after release.
- Input side:
  - in_ready = (level != DEPTH), combinational from registered state only.
  - Push occurs when in_valid && in_ready. in_data and a 3-bit flag set are written at the write pointer on the clock edge.
  - Flags are computed at push time:
    - nan = (in_data == 16'hFFFF)
    - zero = (in_data == 16'h0000)
    - neg = in_data[15] && !nan
- Overflow:
  - When in_valid && !in_ready, drop_cnt increments, saturating at 8'hFF.
  - The dropped data is lost. The FIFO is not modified.
- Full FIFO with simultaneous pop: in_ready stays 0 for that cycle. There is no same-cycle pass-through when full.
- Pointers: the write and read pointers wrap modulo DEPTH.
- level update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Output FSM, states IDLE, HDR, MSB, LSB:
  - IDLE: out_valid=0, out_byte=8'h00. If level != 0 at a clock edge, go to HDR.
  - HDR: out_valid=1, out_byte = {4'hA, 1'b0, nan, zero, neg} of the FIFO head.
  - MSB: out_valid=1, out_byte = head[15:8].
  - LSB: out_valid=1, out_byte = head[7:0].
  - Advance HDR→MSB→LSB only on a clock edge with out_valid && out_ready.
  - While out_ready=0, state, out_valid and out_byte hold stable. No byte is ever retracted.
  - On LSB acceptance, pop the head. Go to HDR if level after the pop is nonzero; otherwise go to IDLE. Back-to-back frames therefore have zero idle cycles.
- Latency: a push on edge k into an empty FIFO in IDLE gives out_valid=1 (header) after edge k+1.
- Throughput: at most 1 byte per cycle; one result per 3 accepted bytes.
- Head stability: the FIFO head does not change while a frame is in progress, because pops occur only at LSB acceptance.

Test Plan:
- Reset, then push 16'h3E00, hold out_ready=1 → out_valid rises 1 cycle after the push; bytes 8'hA0, 8'h3E, 8'h00 on consecutive cycles; then out_valid=0 and level=0.
- Push 16'hFFFF, 16'h0000, 16'hBE00 back-to-back with out_ready=1 → bytes A4 FF FF, A2 00 00, A1 BE 00 with no gap between frames.
- out_ready=0 with 6 pushes → level=4, in_ready=0, drop_cnt=2. Then out_ready=1 → exactly 4 frames out, in original order.
- Toggle out_ready 1,0,0,1,0,1 during a frame → each byte is held stable while out_ready=0; no duplicated or skipped bytes.
- Assert rst_n=0 while the FSM is in MSB with 3 entries queued → out_valid=0, level=0 and drop_cnt=0 immediately. After release the output stays idle until a new push.
- Push 300 results with out_ready=0 → drop_cnt saturates at 8'hFF.
